perf_counter_bank: RTL and testbench

Parametrised bank of hardware performance counters for the SoC: one free-running cycle counter plus NUM_CH gated event counters.
- Atomic snapshot into shadow registers.
- Registered indexed read port and sticky overflow flags.
- Optional PC-stall watchdog.
Sits beside the CPU and is fed by CPU event strobes and the current PC. Gives silicon and simulation the cycle/progress visibility previously available only in the bench.

---
 rtl/perf_pkg.sv | 18 +
 rtl/perf_ctr_cell.sv | 35 +++
 rtl/perf_counter_bank.sv | 107 ++++++++++
 tb/tb_perf_counter_bank.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/perf_pkg.sv
// Shared constants for the performance counter bank: counter-cell indexing,
// select encoding and configuration limits.
package perf_pkg;
  // Cell 0 is the cycle counter, and its ovf_o bit is bit 0.
  localparam int CYC_IDX = 0;
  // Select value k addresses event channel k - CH_SEL_BASE.
  localparam int CH_SEL_BASE = 1;

  localparam int NUM_CH_MIN = 1;
  localparam int NUM_CH_MAX = 15;
  localparam int CNT_W_MIN  = 8;
  localparam int CNT_W_MAX  = 64;

  function automatic bit cfg_ok(input int num_ch, input int cnt_w);
    return (num_ch >= NUM_CH_MIN) && (num_ch <= NUM_CH_MAX) &&
           (cnt_w >= CNT_W_MIN) && (cnt_w <= CNT_W_MAX);
  endfunction
endpackage

// File: rtl/perf_ctr_cell.sv
// One counter slot: live counter with load/increment, a snapshot shadow,
// and a sticky overflow flag set only on an increment wrap.
module perf_ctr_cell #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             load,
  input  logic [CNT_W-1:0] load_data,
  input  logic             snap,
  input  logic             ovf_clr,
  output logic [CNT_W-1:0] shadow,
  output logic             ovf
);
  logic [CNT_W-1:0] cnt;
  logic             wrap;

  // A load suppresses the increment, so it can never produce a wrap.
  assign wrap = inc && !load && (cnt == '1);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      shadow <= '0;
      ovf    <= 1'b0;
    end else begin
      if (load)     cnt <= load_data;
      else if (inc) cnt <= cnt + 1'b1;
      if (snap)     shadow <= cnt;
      if (wrap)         ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end
endmodule

// File: rtl/perf_counter_bank.sv
// Cycle counter plus NUM_CH gated event counters with atomic snapshot,
// registered shadow read port and sticky overflow. PERF_WATCHDOG_EN adds a PC-stall watchdog.
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 32,
  parameter int PC_W        = 32,
  parameter int STALL_LIMIT = 1024,
  parameter int SEL_W       = $clog2(NUM_CH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ev_i,
  input  logic [NUM_CH-1:0] cnt_en_i,
  input  logic              wr_en_i,
  input  logic [SEL_W-1:0]  wr_sel_i,
  input  logic [CNT_W-1:0]  wr_data_i,
  input  logic              snap_i,
  output logic              snap_done_o,
  input  logic              rd_en_i,
  input  logic [SEL_W-1:0]  rd_sel_i,
  output logic [CNT_W-1:0]  rd_data_o,
  output logic              rd_valid_o,
  output logic [NUM_CH:0]   ovf_o,
  input  logic              ovf_clr_i,
  input  logic [PC_W-1:0]   pc_i,
  output logic              hang_o
);
  if (!cfg_ok(NUM_CH, CNT_W)) begin : g_bad_cfg
    $error("perf_counter_bank: NUM_CH or CNT_W out of range");
  end

  logic [NUM_CH:0]  inc_vec;
  logic [CNT_W-1:0] shadow [NUM_CH+1];
  logic [CNT_W-1:0] rd_mux;

  assign inc_vec[CYC_IDX]                = 1'b1;
  assign inc_vec[NUM_CH:CH_SEL_BASE]     = ev_i & cnt_en_i;

  for (genvar i = 0; i <= NUM_CH; i++) begin : g_cell
    perf_ctr_cell #(.CNT_W(CNT_W)) u_cell (
      .clk       (clk),
      .reset     (reset),
      .inc       (inc_vec[i]),
      .load      (wr_en_i && (wr_sel_i == SEL_W'(i))),
      .load_data (wr_data_i),
      .snap      (snap_i),
      .ovf_clr   (ovf_clr_i),
      .shadow    (shadow[i]),
      .ovf       (ovf_o[i])
    );
  end

  // Out-of-range selects match no slot and read back as zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i <= NUM_CH; i++) begin
      if (rd_sel_i == SEL_W'(i)) rd_mux = shadow[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_o   <= '0;
      rd_valid_o  <= 1'b0;
      snap_done_o <= 1'b0;
    end else begin
      if (rd_en_i) rd_data_o <= rd_mux;
      rd_valid_o  <= rd_en_i;
      snap_done_o <= snap_i;
    end
  end

`ifdef PERF_WATCHDOG_EN
  localparam int STALL_W = $clog2(STALL_LIMIT + 1);

  logic [PC_W-1:0]    pc_q;
  logic               pc_vld;
  logic [STALL_W-1:0] stall_cnt;

  // pc_vld marks that pc_q holds a real sample; the first cycle only captures.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= '0;
      pc_vld    <= 1'b0;
      stall_cnt <= '0;
    end else begin
      pc_q   <= pc_i;
      pc_vld <= 1'b1;
      if (!pc_vld) begin
        stall_cnt <= '0;
      end else if (pc_i == pc_q) begin
        if (stall_cnt != STALL_W'(STALL_LIMIT)) stall_cnt <= stall_cnt + 1'b1;
      end else begin
        stall_cnt <= '0;
      end
    end
  end

  assign hang_o = (stall_cnt == STALL_W'(STALL_LIMIT));
`else
  logic unused_wd;
  assign unused_wd = ^{pc_i, STALL_LIMIT[0]};
  assign hang_o    = 1'b0;
`endif
endmodule

// File: tb/tb_perf_counter_bank.sv
// Bench for perf_counter_bank: directed steps from the block's use cases,
// then randomized traffic, all checked against a behavioural model.
module tb_perf_counter_bank;
  localparam int NCH  = 4;
  localparam int CW   = 8;
  localparam int PCW  = 32;
  localparam int SLIM = 16;
  localparam int SW   = 3;
  localparam int CMAX = (1 << CW) - 1;
`ifdef PERF_WATCHDOG_EN
  localparam bit WD_ON = 1'b1;
`else
  localparam bit WD_ON = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [NCH-1:0] ev, en;
  logic           wr_en, snap, rd_en, ovf_clr;
  logic [SW-1:0]  wr_sel, rd_sel;
  logic [CW-1:0]  wr_data;
  logic [PCW-1:0] pc;
  logic           snap_done, rd_valid, hang;
  logic [CW-1:0]  rd_data;
  logic [NCH:0]   ovf;

  perf_counter_bank #(
    .NUM_CH(NCH), .CNT_W(CW), .PC_W(PCW), .STALL_LIMIT(SLIM)
  ) dut (
    .clk(clk), .reset(reset), .ev_i(ev), .cnt_en_i(en),
    .wr_en_i(wr_en), .wr_sel_i(wr_sel), .wr_data_i(wr_data),
    .snap_i(snap), .snap_done_o(snap_done),
    .rd_en_i(rd_en), .rd_sel_i(rd_sel), .rd_data_o(rd_data), .rd_valid_o(rd_valid),
    .ovf_o(ovf), .ovf_clr_i(ovf_clr), .pc_i(pc), .hang_o(hang)
  );

  int n_vec = 0;
  int n_err = 0;

  // behavioural reference model
  int             m_cnt [NCH+1];
  int             m_shd [NCH+1];
  logic [NCH:0]   m_ovf;
  int             m_rd_data;
  bit             m_rd_valid, m_snap_done;
  logic [PCW-1:0] m_pc;
  bit             m_pc_vld;
  int             m_stall;
  logic [CW-1:0]  exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int  old [NCH+1];
    bit  inc, wrap;
    if (reset) begin
      for (int i = 0; i <= NCH; i++) begin m_cnt[i] = 0; m_shd[i] = 0; end
      m_ovf = '0; m_rd_data = 0; m_rd_valid = 0; m_snap_done = 0;
      m_pc = '0; m_pc_vld = 0; m_stall = 0;
      exp_q.delete();
    end else begin
      old = m_cnt;
      for (int i = 0; i <= NCH; i++) begin
        if (i == 0) inc = 1'b1;
        else        inc = ev[i-1] && en[i-1];
        wrap = 1'b0;
        if (wr_en && (int'(wr_sel) == i)) m_cnt[i] = int'(wr_data);
        else if (inc) begin
          wrap     = (old[i] == CMAX);
          m_cnt[i] = (old[i] + 1) % (CMAX + 1);
        end
        if (wrap)         m_ovf[i] = 1'b1;
        else if (ovf_clr) m_ovf[i] = 1'b0;
      end
      m_rd_valid = rd_en;
      if (rd_en) begin
        m_rd_data = (int'(rd_sel) <= NCH) ? m_shd[rd_sel] : 0;
        exp_q.push_back(CW'(m_rd_data));
      end
      if (snap) m_shd = old;
      m_snap_done = snap;
      if (!m_pc_vld) begin
        m_pc_vld = 1; m_stall = 0;
      end else if (pc == m_pc) begin
        m_stall = (m_stall < SLIM) ? m_stall + 1 : SLIM;
      end else begin
        m_stall = 0;
      end
      m_pc = pc;
    end
  endtask

  // driver: one clock edge, update model, then compare away from the edge
  task automatic tick();
    logic [CW-1:0] exp_rd;
    @(posedge clk);
    model_edge();
    #1;
    check("rd_valid", rd_valid, m_rd_valid);
    check("snap_done", snap_done, m_snap_done);
    check("ovf", ovf, m_ovf);
    check("hang", hang, WD_ON ? (m_stall == SLIM) : 1'b0);
    if (m_rd_valid && exp_q.size() > 0) begin
      exp_rd = exp_q.pop_front();
      check("rd_data_sb", rd_data, exp_rd);
    end else begin
      check("rd_data_hold", rd_data, m_rd_data);
    end
  endtask

  task automatic idle();
    ev = '0; en = '0; wr_en = 0; wr_sel = '0; wr_data = '0;
    snap = 0; rd_en = 0; rd_sel = '0; ovf_clr = 0;
  endtask

  initial begin
    int exp_old;
    idle(); pc = '0; reset = 1;
    repeat (3) tick();
    check("rst_rd_data", rd_data, 0);
    check("rst_ovf", ovf, 0);
    check("rst_rd_valid", rd_valid, 0);

    // cycle counter value on the 11th cycle after release
    reset = 0;
    repeat (10) tick();
    snap = 1; tick(); idle();
    check("snap_done_pulse", snap_done, 1);
    rd_en = 1; rd_sel = 0; tick(); idle();
    check("cyc_read", rd_data, 8'd10);
    check("cyc_read_valid", rd_valid, 1);
    check("snap_done_once", snap_done, 0);
    tick();
    check("rd_valid_drop", rd_valid, 0);
    check("rd_data_hold_dir", rd_data, 8'd10);

    // ch1 wraps FE -> FF -> 00 -> 01
    wr_en = 1; wr_sel = 2; wr_data = 8'hFE; tick(); idle();
    ev[1] = 1; en[1] = 1; repeat (3) tick(); idle();
    snap = 1; tick(); idle();
    rd_en = 1; rd_sel = 2; tick(); idle();
    check("ch1_wrap_read", rd_data, 8'h01);
    check("ch1_ovf", ovf, 5'b00100);

    // load beats a same-cycle increment
    wr_en = 1; wr_sel = 3; wr_data = 8'h40; ev[2] = 1; en[2] = 1; tick(); idle();
    snap = 1; tick(); idle();
    rd_en = 1; rd_sel = 3; tick(); idle();
    check("ch2_load_prio", rd_data, 8'h40);
    check("ch2_no_ovf", ovf, 5'b00100);

    // clear in the wrap cycle keeps the new flag
    wr_en = 1; wr_sel = 1; wr_data = 8'hFF; tick(); idle();
    ev[0] = 1; en[0] = 1; ovf_clr = 1; tick(); idle();
    check("clr_vs_wrap", ovf, 5'b00010);
    ovf_clr = 1; tick(); idle();
    check("clr_alone", ovf, 5'b00000);

    // out-of-range read, then read racing a snapshot
    rd_en = 1; rd_sel = 7; tick(); idle();
    check("oor_read", rd_data, 0);
    check("oor_valid", rd_valid, 1);
    tick(); tick();
    exp_old = m_shd[0];
    snap = 1; rd_en = 1; rd_sel = 0; tick(); idle();
    check("read_snap_same", rd_data, exp_old);
    rd_en = 1; rd_sel = 0; tick(); idle();
    check("read_after_snap", rd_data, m_rd_data);

    // watchdog: 16 equal comparisons raise hang, a PC change drops it
    reset = 1; tick(); reset = 0;
    pc = 32'h100;
    repeat (16) tick();
    check("hang_before_limit", hang, 0);
    tick();
    check("hang_at_limit", hang, WD_ON);
    pc = 32'h104; tick();
    check("hang_drop", hang, 0);

    // randomized traffic, including occasional mid-operation resets
    repeat (600) begin
      reset   = ($urandom_range(0, 149) == 0);
      ev      = NCH'($urandom);
      en      = NCH'($urandom);
      wr_en   = ($urandom_range(0, 9) == 0);
      wr_sel  = SW'($urandom_range(0, 7));
      wr_data = CW'($urandom);
      snap    = ($urandom_range(0, 4) == 0);
      rd_en   = 1'($urandom_range(0, 1));
      rd_sel  = SW'($urandom_range(0, 7));
      ovf_clr = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 29) == 0) pc = PCW'($urandom_range(0, 3) * 4);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
